// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its UART-facing sequencer:
// default widths, sequencer state encoding and MIPS funct op codes.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int OP_W_DEF   = 6;

  typedef enum logic [2:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    SEND    = 3'd3,
    WAIT_TX = 3'd4
  } state_e;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 6'b100000;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 6'b100010;
  localparam logic [OP_W_DEF-1:0] OP_AND = 6'b100100;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 6'b100101;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 6'b100110;
  localparam logic [OP_W_DEF-1:0] OP_SRA = 6'b000011;
  localparam logic [OP_W_DEF-1:0] OP_SRL = 6'b000010;
  localparam logic [OP_W_DEF-1:0] OP_NOR = 6'b100111;

endpackage

// File: rtl/alu_uart_interface_if.sv
// Signal bundle between the sequencer (master) and the UART pair plus ALU
// that surround it (slave).
interface alu_uart_interface_if
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
);

  logic [DATA_W-1:0] rx_data;
  logic              rx_done;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] tx_data;
  logic              tx_start;
  logic              tx_done;
  logic              busy;
  logic              overrun;

  modport master (
    input  rx_data, rx_done, alu_result, tx_done,
    output alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun
  );

  modport slave (
    output rx_data, rx_done, alu_result, tx_done,
    input  alu_a, alu_b, alu_op, tx_data, tx_start, busy, overrun
  );

endinterface

// File: rtl/alu.sv
// Combinational ALU decoding MIPS funct codes; shifts take their amount
// from operand B. Unknown codes produce zero.
module alu
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [OP_W-1:0]   op_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    result_o = '0;
    unique case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      OP_NOR:  result_o = ~(a_i | b_i);
      OP_SRL:  result_o = a_i >> b_i;
      OP_SRA:  result_o = $signed(a_i) >>> b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_uart_interface.sv
// Sequencer: gathers A, B and op bytes from the receiver, presents them to
// the ALU, then ships the one-byte result to the transmitter.
module alu_uart_interface
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input logic                 clk,
  input logic                 rst_n,
  alu_uart_interface_if.master bus
);

  state_e            state_q,    state_d;
  logic [DATA_W-1:0] alu_a_q,    alu_a_d;
  logic [DATA_W-1:0] alu_b_q,    alu_b_d;
  logic [OP_W-1:0]   alu_op_q,   alu_op_d;
  logic [DATA_W-1:0] tx_data_q,  tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              busy_q,     busy_d;
  logic              overrun_q,  overrun_d;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples the
    // pre-edge value of its _d, regardless of statement order.
    if (!rst_n) begin
      state_q    <= WAIT_A;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    // NOTE: every _d gets a hold/default value up front, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    busy_d     = busy_q;
    overrun_d  = overrun_q;

    unique case (state_q)
      WAIT_A: if (bus.rx_done) begin
        alu_a_d   = bus.rx_data;
        overrun_d = 1'b0;
        state_d   = WAIT_B;
      end
      WAIT_B: if (bus.rx_done) begin
        alu_b_d = bus.rx_data;
        state_d = WAIT_OP;
      end
      WAIT_OP: if (bus.rx_done) begin
        alu_op_d = bus.rx_data[OP_W-1:0];
        busy_d   = 1'b1;
        state_d  = SEND;
      end
      // The ALU has had the whole SEND cycle to settle on the new op code.
      SEND: begin
        tx_data_d  = bus.alu_result;
        tx_start_d = 1'b1;
        state_d    = WAIT_TX;
        if (bus.rx_done) overrun_d = 1'b1;
      end
      WAIT_TX: begin
        if (bus.rx_done) overrun_d = 1'b1;
        if (bus.tx_done) begin
          busy_d  = 1'b0;
          state_d = WAIT_A;
        end
      end
      default: state_d = WAIT_A;
    endcase
  end

  assign bus.alu_a    = alu_a_q;
  assign bus.alu_b    = alu_b_q;
  assign bus.alu_op   = alu_op_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_start = tx_start_q;
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Sequencer that feeds the ALU from a byte stream and returns its result. It sits between the UART receiver/transmitter pair and the combinational ALU. It collects three received bytes in order (operand A, operand B, operation code), drives them to the ALU as registered signals, then hands the ALU result to the transmitter as one byte. It then waits for transmit completion before accepting the next frame.

## Interface

- `DATA_W`, 8, operand/result width; equals the UART byte width
- `OP_W`, 6, ALU operation-code width (MIPS funct field)

- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset; synchronous, active-low
- `rx_data`  in  DATA_W  received byte, valid when `rx_done` is high
- `rx_done`  in  1  one-cycle pulse from receiver, byte available
- `alu_a`  out  DATA_W  operand A to ALU, registered
- `alu_b`  out  DATA_W  operand B to ALU, registered
- `alu_op`  out  OP_W  operation code to ALU, registered
- `alu_result`  in  DATA_W  combinational ALU result
- `tx_data`  out  DATA_W  byte to transmitter, registered, held stable until `tx_done`
- `tx_start`  out  1  one-cycle pulse, start transmission
- `tx_done`  in  1  one-cycle pulse from transmitter, byte sent
- `busy`  out  1  high from op-byte capture until `tx_done`
- `overrun`  out  1  sticky; a byte arrived while busy and was dropped

## Operation

- States: `WAIT_A`, `WAIT_B`, `WAIT_OP`, `SEND`, `WAIT_TX`; reset state `WAIT_A`.
- `WAIT_A` + `rx_done`: `alu_a <= rx_data`; clear `overrun`; go to `WAIT_B`.
- `WAIT_B` + `rx_done`: `alu_b <= rx_data`; go to `WAIT_OP`.
- `WAIT_OP` + `rx_done`: `alu_op <= rx_data[OP_W-1:0]`, upper bits discarded; `busy <= 1`; go to `SEND`.
- `SEND`, unconditional, one cycle: `tx_data <= alu_result`; `tx_start <= 1`; go to `WAIT_TX`.
- `WAIT_TX` + `tx_done`: `busy <= 0`; go to `WAIT_A`.
- In states without a listed transition, the FSM holds state and all outputs.
- `rx_done` in `SEND` or `WAIT_TX`: byte dropped, `overrun <= 1`. `overrun` stays set until the next byte is accepted in `WAIT_A`.
- `tx_done` outside `WAIT_TX` is ignored.
- `alu_a`, `alu_b`, `alu_op` hold their values after a frame until overwritten; the ALU output stays observable.
- No arithmetic is performed in this block. Widths pass straight through, and `alu_result` is captured unmodified.

## Timing

- Reset values: `alu_a = 0`, `alu_b = 0`, `alu_op = 0`, `tx_data = 0`, `tx_start = 0`, `busy = 0`, `overrun = 0`, state `WAIT_A`.
- An active `rst_n` at any edge, including mid-frame or mid-transmit, forces all reset values at that edge. `rst_n` has priority over every `rx_done`/`tx_done`.
- Edge E0 samples `rx_done` for the op byte. At E0, `alu_op` updates and the FSM enters `SEND`; the ALU settles during that cycle.
- At E0+1, `tx_data` and `tx_start` go high.
- At E0+2, `tx_start` falls; `tx_start` is exactly one cycle wide.
- `tx_done` is honoured in any `WAIT_TX` cycle, including the first. At that same edge the FSM is in `WAIT_A`, so an `rx_done` in the following cycle is accepted.
- Back-to-back `rx_done` on consecutive cycles are each accepted: one byte per cycle, no gap required.

## Structure

- Shared package `alu_pkg`:
  - default `DATA_W`/`OP_W`
  - FSM state enum (3-bit)
  - ALU op-code constants: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, SRA 6'b000011, SRL 6'b000010, NOR 6'b100111
- The ALU uses the same package.
- No sub-module: a single FSM with data registers. The ALU, UART receiver and transmitter are instantiated beside this block at top level.

## Test plan

- Bytes 0x05, 0x03, 0x20 with a real ALU attached -> `alu_op = 0x20`, `tx_start` one cycle at E0+1, `tx_data = 0x08`; `busy` high until `tx_done`.
- Bytes 0x03, 0x05, 0x22 -> `tx_data = 0xFE` (SUB wrap); a second frame 0x80, 0x02, 0x03 -> `tx_data = 0xE0` (SRA sign fill).
- Op byte 0xE4 with A = 0xF0, B = 0x3C -> `alu_op = 0x24`, `tx_data = 0x30` (upper bits ignored).
- `rx_done` with 0x55 pulsed during `WAIT_TX` -> byte dropped, `overrun = 1`, `alu_a` unchanged. Next frame 0x01, 0x01, 0x25 -> `overrun` clears on the A byte, `tx_data = 0x01`.
- Reset low for one edge after A and B are accepted -> all outputs 0, state `WAIT_A`. Next bytes 0x02, 0x02, 0x26 -> `tx_data = 0x00`.
- `tx_done` pulsed in `WAIT_A`/`WAIT_B` -> no state change. `tx_done` in the first `WAIT_TX` cycle, then `rx_done` the next cycle -> byte captured as A.
